// File: rtl/state_variable_filter.sv
// Chamberlin state-variable filter: 12-bit signed samples, Q2.10 unsigned F and 1/Q coefficients.
// Optional SVF_SATURATE_EN clamps every intermediate result instead of wrapping it to 12 bits.
module state_variable_filter (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_in,
    input  logic        [11:0] F,
    input  logic        [11:0] Q,
    input  logic        [11:0] x,
    output logic signed [11:0] yh,
    output logic signed [11:0] yb,
    output logic signed [11:0] yl,
    output logic signed [11:0] yn
);

    localparam int SW = 18;

    function automatic logic signed [SW-1:0] sx(input logic signed [11:0] v);
        return {{(SW-12){v[11]}}, v};
    endfunction

    // Unsigned coefficient times signed state, floored by the Q2.10 scale.
    function automatic logic signed [SW-1:0] coef_mul(input logic [11:0] c,
                                                      input logic signed [11:0] v);
        logic signed [24:0] p;
        p = $signed({1'b0, c}) * v;
        return SW'(p >>> 10);
    endfunction

    function automatic logic signed [11:0] fit(input logic signed [SW-1:0] v);
`ifdef SVF_SATURATE_EN
        if (v > 18'sd2047)
            return 12'sd2047;
        else if (v < -18'sd2048)
            return -12'sd2048;
        else
            return v[11:0];
`else
        return v[11:0];
`endif
    endfunction

    logic signed [11:0] l_nx, h_nx, b_nx, n_nx;

    // Each stage reuses the already reduced 12-bit result of the previous one.
    always_comb begin
        l_nx = fit(sx(yl) + coef_mul(F, yb));
        h_nx = fit(sx($signed(x)) - sx(l_nx) - coef_mul(Q, yb));
        b_nx = fit(sx(yb) + coef_mul(F, h_nx));
        n_nx = fit(sx(h_nx) + sx(l_nx));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            yh <= '0;
            yb <= '0;
            yl <= '0;
            yn <= '0;
        end else if (en_in) begin
            yh <= h_nx;
            yb <= b_nx;
            yl <= l_nx;
            yn <= n_nx;
        end
    end

endmodule

// File: tb/tb_state_variable_filter.sv
// Randomized self-checking bench for state_variable_filter against an integer reference model.
// Honours SVF_SATURATE_EN the same way the design does.
module tb_state_variable_filter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_in = 1'b0;
    logic [11:0] F = '0, Q = '0, x = '0;
    logic signed [11:0] yh, yb, yl, yn;

    int total = 0;
    int bad   = 0;
    int ml = 0, mb = 0, mh = 0, mn = 0;

    state_variable_filter dut (
        .clk(clk), .rst(rst), .en_in(en_in), .F(F), .Q(Q), .x(x),
        .yh(yh), .yb(yb), .yl(yl), .yn(yn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // floor(c*v/1024) with exact integer arithmetic
    function automatic int scale(input int c, input int v);
        int p, r;
        p = c * v;
        r = ((p % 1024) + 1024) % 1024;
        return (p - r) / 1024;
    endfunction

    function automatic int reduce(input int v);
`ifdef SVF_SATURATE_EN
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
`else
        return (((v + 2048) % 4096) + 4096) % 4096 - 2048;
`endif
    endfunction

    function automatic int sgn12(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_step();
        int l, h, b, n;
        if (!en_in) return;
        l = reduce(ml + scale(int'(F), mb));
        h = reduce(sgn12(x) - l - scale(int'(Q), mb));
        b = reduce(mb + scale(int'(F), h));
        n = reduce(h + l);
        ml = l; mh = h; mb = b; mn = n;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".yh"}, int'(yh), mh);
        chk({tag, ".yb"}, int'(yb), mb);
        chk({tag, ".yl"}, int'(yl), ml);
        chk({tag, ".yn"}, int'(yn), mn);
    endtask

    // Inputs are stable here; the model sees what the DUT samples at the edge.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic zero_model();
        ml = 0; mb = 0; mh = 0; mn = 0;
    endtask

    initial begin
        int xi;
        // reset state
        #12;
        chk("rst.yh", int'(yh), 0);
        chk("rst.yn", int'(yn), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // silence
        en_in = 1'b1; F = 12'h400; Q = 12'h5A8; x = '0;
        for (int i = 0; i < 20; i++) tick("silence");

        // step, with hand-derived constants
        x = 12'd512;
        tick("step1");
        chk("step1.yl", int'(yl), 0);
        chk("step1.yh", int'(yh), 512);
        chk("step1.yb", int'(yb), 512);
        chk("step1.yn", int'(yn), 512);
        tick("step2");
        chk("step2.yl", int'(yl), 512);
        chk("step2.yh", int'(yh), -724);
        chk("step2.yb", int'(yb), -212);
        chk("step2.yn", int'(yn), -212);

        // enable gating
        en_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = 12'($urandom);
            F = 12'($urandom);
            tick("hold");
            chk("hold.yb", int'(yb), -212);
        end
        en_in = 1'b1; F = 12'h400; x = 12'd512;
        for (int i = 0; i < 4; i++) tick("resume");

        // async reset mid-operation, checked before the next edge
        rst = 1'b0;
        #2;
        zero_model();
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("rst_held");
        rst = 1'b1;

        // overflow case
        F = 12'hFFF; Q = 12'h000; x = 12'h800;
        tick("ovf");
        chk("ovf.yl", int'(yl), 0);
        chk("ovf.yh", int'(yh), -2048);
        chk("ovf.yn", int'(yn), -2048);
`ifdef SVF_SATURATE_EN
        chk("ovf.yb", int'(yb), -2048);
`else
        chk("ovf.yb", int'(yb), 2);
`endif

        // F=0 freezes the state variables
        F = 12'h000; Q = 12'h5A8;
        for (int i = 0; i < 3; i++) begin
            x = 12'($urandom);
            tick("f0");
        end

        // Butterworth sine stream
        rst = 1'b0; #2; zero_model(); rst = 1'b1;
        F = 12'h200; Q = 12'h5A8;
        for (int i = 0; i < 300; i++) begin
            xi = int'(1500.0 * $sin(2.0 * 3.14159265 * real'(i) / 37.0));
            x = 12'(xi);
            tick("sine");
        end

        // fully random coefficients, data and enable
        for (int i = 0; i < 400; i++) begin
            x = 12'($urandom);
            F = 12'($urandom);
            Q = 12'($urandom);
            en_in = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
